// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter and drives the instruction-memory address.
// The PC either advances by PC_INC or loads the branch target on every non-reset rising edge.

module fetch_next_pc_mux #(
   parameter int unsigned N = 64
) (
   input  logic         i_sel,
   input  logic [N-1:0] i_seq,
   input  logic [N-1:0] i_branch,
   output logic [N-1:0] o_next
);
   assign o_next = i_sel ? i_branch : i_seq;
endmodule

module fetch_pc_adder #(
   parameter int unsigned N      = 64,
   parameter int unsigned PC_INC = 4
) (
   input  logic [N-1:0] i_pc,
   output logic [N-1:0] o_pc_inc
);
   // Unsigned modulo-2^N add; carry out of the top bit is simply dropped.
   assign o_pc_inc = i_pc + N'(PC_INC);
endmodule

module fetch_pc_reg #(
   parameter int unsigned N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] i_d,
   output logic [N-1:0] o_q
);
   logic [N-1:0] r_pc;

   // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_pc <= '0;
      else       r_pc <= i_d;
   end

   assign o_q = r_pc;
endmodule

module fetch_stage #(
   parameter int unsigned N      = 64,
   parameter int unsigned PC_INC = 4
) (
   input  logic         PCSrc_F,
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] PCBranch_F,
   output logic [N-1:0] imem_addr_F
);
   logic [N-1:0] w_pc;
   logic [N-1:0] w_pc_plus;
   logic [N-1:0] w_next_pc;

   fetch_pc_adder #(.N(N), .PC_INC(PC_INC)) u_adder (
      .i_pc     (w_pc),
      .o_pc_inc (w_pc_plus)
   );

   fetch_next_pc_mux #(.N(N)) u_mux (
      .i_sel    (PCSrc_F),
      .i_seq    (w_pc_plus),
      .i_branch (PCBranch_F),
      .o_next   (w_next_pc)
   );

   fetch_pc_reg #(.N(N)) u_pc (
      .clk   (clk),
      .reset (reset),
      .i_d   (w_next_pc),
      .o_q   (w_pc)
   );

   assign imem_addr_F = w_pc;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a per-cycle PC model compared on every falling edge,
// plus directed steps with hand-computed literal addresses.

module tb_fetch_stage;
   localparam int unsigned N = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         PCSrc_F;
   logic [N-1:0] PCBranch_F;
   logic [N-1:0] imem_addr_F;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] exp_pc = '0;
   bit           cmp_en = 1'b0;

   fetch_stage #(.N(N), .PC_INC(4)) dut (
      .PCSrc_F     (PCSrc_F),
      .clk         (clk),
      .reset       (reset),
      .PCBranch_F  (PCBranch_F),
      .imem_addr_F (imem_addr_F)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, req, $time);
      end
   endtask

   // Model: the PC is the address of the instruction fetched this cycle; reset zeroes it at once.
   always @(posedge reset) exp_pc = '0;
   always @(posedge clk) begin
      if (reset)        exp_pc = '0;
      else if (PCSrc_F) exp_pc = PCBranch_F;
      else              exp_pc = exp_pc + 64'd4;
   end

   always @(negedge clk) begin
      if (cmp_en) check("model", imem_addr_F, exp_pc);
   end

   // Apply inputs, take one rising edge, then sample just after it.
   task automatic step(input logic src, input logic [N-1:0] br);
      PCSrc_F    = src;
      PCBranch_F = br;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      PCSrc_F    = 1'b0;
      PCBranch_F = 64'd127;
      #1;
      check("reset_async_t0", imem_addr_F, 64'd0);
      cmp_en = 1'b1;

      // Reset hold over several edges, even with a branch target presented.
      repeat (3) begin
         step(1'b0, 64'd127);
         check("reset_hold", imem_addr_F, 64'd0);
      end
      step(1'b1, 64'd127);
      check("reset_beats_branch", imem_addr_F, 64'd0);
      PCSrc_F = 1'b0;
      reset   = 1'b0;
      #1;
      check("reset_release_no_edge", imem_addr_F, 64'd0);

      // Sequential fetch.
      step(1'b0, 64'd127); check("seq_4",  imem_addr_F, 64'd4);
      step(1'b0, 64'd127); check("seq_8",  imem_addr_F, 64'd8);
      step(1'b0, 64'd127); check("seq_12", imem_addr_F, 64'd12);

      // Select change must not show combinationally.
      PCSrc_F = 1'b1;
      #1;
      check("no_comb_path", imem_addr_F, 64'd12);

      // Branch taken and held, then resume sequential from an unaligned target.
      step(1'b1, 64'd127); check("branch_127", imem_addr_F, 64'd127);
      step(1'b1, 64'd127); check("branch_hold", imem_addr_F, 64'd127);
      step(1'b0, 64'd127); check("resume_131", imem_addr_F, 64'd131);
      step(1'b0, 64'd127); check("resume_135", imem_addr_F, 64'd135);

      // Async reset mid-cycle while PC = 8.
      step(1'b1, 64'd4);   check("load_4", imem_addr_F, 64'd4);
      step(1'b0, 64'd0);   check("pc_8",   imem_addr_F, 64'd8);
      reset = 1'b1;
      #1;
      check("async_reset_mid", imem_addr_F, 64'd0);
      step(1'b0, 64'd0);   check("reset_hold_mid", imem_addr_F, 64'd0);
      reset = 1'b0;
      step(1'b0, 64'd0);   check("post_reset_4", imem_addr_F, 64'd4);

      // Wrap-around at the top of the address space.
      step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC); check("branch_top", imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
      step(1'b0, 64'd0);   check("wrap_0", imem_addr_F, 64'd0);
      step(1'b0, 64'd0);   check("wrap_4", imem_addr_F, 64'd4);

      // Branch to a wide, odd target and continue.
      step(1'b1, 64'h8000_0000_0000_0001); check("branch_wide", imem_addr_F, 64'h8000_0000_0000_0001);
      step(1'b0, 64'd0);   check("wide_plus4", imem_addr_F, 64'h8000_0000_0000_0005);

      @(negedge clk);
      cmp_en = 1'b0;
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
